// File: rtl/seg7_scan_rx.sv
`timescale 1ns/1ps
// seg7_scan_rx
// Receives a multiplexed 4-digit seven-segment display bus and reassembles
// the scanned digits into a 16-bit hex value.
//
// Each digit selection must hold steady for STABLE_CYC consecutive cycles
// before it is sampled, and it is sampled once per selection episode.
// Frames always begin at digit 0. A frame is emitted once all four digits
// have been captured.
//
// Optional feature: define SEG7_SCAN_RX_BLANK_EN to accept the blank pattern
// (all segments off) as a valid digit that decodes to 0.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   an[3:0]    - active-low digit selects; bit i selects digit i
//   seg[6:0]   - active-high segments, bit0=a .. bit6=g
//   value      - last completed frame, digit i at bits 4i+3:4i
//   value_vld  - one-cycle pulse when value updates
//   frame_err  - set with value_vld if any digit of that frame was invalid
//   bad_mask   - digits of the last frame that decoded invalid
module seg7_scan_rx #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic        value_vld,
    output logic        frame_err,
    output logic [3:0]  bad_mask
);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    // Sampling happens on the cycle the counter steps up to STABLE_CYC-1,
    // i.e. while the registered counter still holds STABLE_CYC-2.
    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYC - 2);

    // Returns {bad, nibble}; unknown patterns give nibble 0 flagged bad.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h3F:   return {1'b0, 4'h0};
            7'h06:   return {1'b0, 4'h1};
            7'h5B:   return {1'b0, 4'h2};
            7'h4F:   return {1'b0, 4'h3};
            7'h66:   return {1'b0, 4'h4};
            7'h6D:   return {1'b0, 4'h5};
            7'h7D:   return {1'b0, 4'h6};
            7'h07:   return {1'b0, 4'h7};
            7'h7F:   return {1'b0, 4'h8};
            7'h6F:   return {1'b0, 4'h9};
            7'h77:   return {1'b0, 4'hA};
            7'h7C:   return {1'b0, 4'hB};
            7'h39:   return {1'b0, 4'hC};
            7'h5E:   return {1'b0, 4'hD};
            7'h79:   return {1'b0, 4'hE};
            7'h71:   return {1'b0, 4'hF};
`ifdef SEG7_SCAN_RX_BLANK_EN
            7'h00:   return {1'b0, 4'h0};
`endif
            default: return {1'b1, 4'h0};
        endcase
    endfunction

    logic [3:0]  an_r;
    logic [6:0]  seg_r;
    logic [3:0]  prev_an_r;
    logic [6:0]  prev_seg_r;
    logic [7:0]  cnt_r;
    logic        sampled_r;
    state_t      state_r;
    logic [15:0] buf_nib_r;
    logic [3:0]  buf_bad_r;
    logic [3:0]  mask_r;

    logic        same_s;
    logic        one_low_s;
    logic [1:0]  cap_idx_s;
    logic [3:0]  cap_bit_s;
    logic        cap_s;
    logic [4:0]  dec_s;

    // Classify the registered selects: exactly one low bit picks a digit.
    always_comb begin
        one_low_s = 1'b0;
        cap_idx_s = 2'd0;
        case (an_r)
            4'b1110: begin one_low_s = 1'b1; cap_idx_s = 2'd0; end
            4'b1101: begin one_low_s = 1'b1; cap_idx_s = 2'd1; end
            4'b1011: begin one_low_s = 1'b1; cap_idx_s = 2'd2; end
            4'b0111: begin one_low_s = 1'b1; cap_idx_s = 2'd3; end
            default: begin one_low_s = 1'b0; cap_idx_s = 2'd0; end
        endcase
    end

    // Stability comparison, capture strobe and digit decode.
    always_comb begin
        same_s    = (an_r == prev_an_r) && (seg_r == prev_seg_r);
        cap_bit_s = one_low_s ? ~an_r : 4'b0000;
        cap_s     = same_s && one_low_s && !sampled_r && (cnt_r == CAP_CNT);
        dec_s     = seg_decode(seg_r);
    end

    // Input sampling, stability tracking, frame assembly FSM and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r       <= 4'hF;
            seg_r      <= 7'h00;
            prev_an_r  <= 4'hF;
            prev_seg_r <= 7'h00;
            cnt_r      <= 8'd0;
            sampled_r  <= 1'b0;
            state_r    <= SYNC;
            buf_nib_r  <= 16'h0000;
            buf_bad_r  <= 4'b0000;
            mask_r     <= 4'b0000;
            value      <= 16'h0000;
            value_vld  <= 1'b0;
            frame_err  <= 1'b0;
            bad_mask   <= 4'b0000;
        end else begin
            an_r       <= an;
            seg_r      <= seg;
            prev_an_r  <= an_r;
            prev_seg_r <= seg_r;

            if (same_s && one_low_s) begin
                if (cnt_r != 8'hFF) begin
                    cnt_r <= cnt_r + 8'd1;
                end
            end else begin
                cnt_r <= 8'd0;
            end

            // Any change ends the selection episode and re-arms sampling.
            if (!same_s) begin
                sampled_r <= 1'b0;
            end else if (cap_s) begin
                sampled_r <= 1'b1;
            end

            value_vld <= 1'b0;

            case (state_r)
                SYNC: begin
                    // Frames are aligned to digit 0; anything else is dropped.
                    if (cap_s && (cap_idx_s == 2'd0)) begin
                        buf_nib_r[3:0] <= dec_s[3:0];
                        buf_bad_r      <= {3'b000, dec_s[4]};
                        mask_r         <= 4'b0001;
                        state_r        <= COLLECT;
                    end
                end
                COLLECT: begin
                    // Recapturing a digit simply overwrites its slot.
                    if (cap_s) begin
                        buf_nib_r[{cap_idx_s, 2'b00} +: 4] <= dec_s[3:0];
                        buf_bad_r[cap_idx_s]               <= dec_s[4];
                        mask_r                             <= mask_r | cap_bit_s;
                        if ((mask_r | cap_bit_s) == 4'hF) begin
                            state_r <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    value     <= buf_nib_r;
                    bad_mask  <= buf_bad_r;
                    frame_err <= |buf_bad_r;
                    value_vld <= 1'b1;
                    // A capture landing here starts the next frame.
                    if (cap_s) begin
                        buf_nib_r[{cap_idx_s, 2'b00} +: 4] <= dec_s[3:0];
                        buf_bad_r <= cap_bit_s & {4{dec_s[4]}};
                        mask_r    <= cap_bit_s;
                    end else begin
                        buf_bad_r <= 4'b0000;
                        mask_r    <= 4'b0000;
                    end
                    state_r <= COLLECT;
                end
                default: begin
                    mask_r    <= 4'b0000;
                    buf_bad_r <= 4'b0000;
                    state_r   <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for seg7_scan_rx: stimulus pushes expected frames,
// a forked monitor pops and compares whenever value_vld is seen.
module tb_seg7_scan_rx;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] value;
    logic        value_vld;
    logic        frame_err;
    logic [3:0]  bad_mask;

    int n_cmp;
    int n_fail;
    logic [20:0] sb[$];   // {frame_err, bad_mask, value}

    seg7_scan_rx #(.STABLE_CYC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .an        (an),
        .seg       (seg),
        .value     (value),
        .value_vld (value_vld),
        .frame_err (frame_err),
        .bad_mask  (bad_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment patterns, g..a
    localparam logic [6:0] P0 = 7'h3F, P1 = 7'h06, P2 = 7'h5B, P3 = 7'h4F;
    localparam logic [6:0] P4 = 7'h66, P5 = 7'h6D, P6 = 7'h7D, P7 = 7'h07;
    localparam logic [6:0] P8 = 7'h7F, P9 = 7'h6F, PA = 7'h77, PB = 7'h7C;
    localparam logic [6:0] PC = 7'h39, PD = 7'h5E, PE = 7'h79, PF = 7'h71;
    localparam logic [6:0] PBAD   = 7'h2A;
    localparam logic [6:0] PBLANK = 7'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic show(input int d, input logic [6:0] p, input int n);
        logic [3:0] one;
        one = 4'b0001;
        an  = ~(one << d);
        seg = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_raw(input logic [3:0] a, input int n);
        an  = a;
        seg = P8;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        show(0, p0, 8);
        show(1, p1, 8);
        show(2, p2, 8);
        show(3, p3, 8);
    endtask

    task automatic expect_frame(input logic [15:0] v, input logic [3:0] b, input logic e);
        sb.push_back({e, b, v});
    endtask

    initial begin
        logic [20:0] ent;
        logic        prev_vld;
        n_cmp    = 0;
        n_fail   = 0;
        prev_vld = 1'b0;
        rst_n    = 1'b0;
        an       = 4'hF;
        seg      = 7'h00;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && value_vld) begin
                    chk("vld_one_cycle", {31'd0, prev_vld}, 32'd0);
                    if (sb.size() == 0) begin
                        chk("unexpected_vld", {16'd0, value}, 32'hFFFF_FFFF);
                    end else begin
                        ent = sb.pop_front();
                        chk("value", {16'd0, value}, {16'd0, ent[15:0]});
                        chk("bad_mask", {28'd0, bad_mask}, {28'd0, ent[19:16]});
                        chk("frame_err", {31'd0, frame_err}, {31'd0, ent[20]});
                    end
                end
                prev_vld = value_vld;
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_value", {16'd0, value}, 32'd0);
        chk("rst_vld", {31'd0, value_vld}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        chk("rst_bad", {28'd0, bad_mask}, 32'd0);
        rst_n = 1'b1;

        // Clean frame 1,2,3,4
        expect_frame(16'h4321, 4'b0000, 1'b0);
        frame(P1, P2, P3, P4);

        // Invalid pattern on digit 2
        expect_frame(16'h4021, 4'b0100, 1'b1);
        frame(P1, P2, PBAD, P4);

        // Partial frame: error must still be held
        show(0, P1, 8);
        show(1, P2, 8);
        chk("err_held", {31'd0, frame_err}, 32'd1);
        chk("bad_held", {28'd0, bad_mask}, 32'h4);
        chk("value_held", {16'd0, value}, 32'h4021);

        // Short asynchronous reset mid-frame
        @(posedge clk);
        #3 rst_n = 1'b0;
        #0.5;
        chk("arst_value", {16'd0, value}, 32'd0);
        chk("arst_vld", {31'd0, value_vld}, 32'd0);
        chk("arst_err", {31'd0, frame_err}, 32'd0);
        chk("arst_bad", {28'd0, bad_mask}, 32'd0);
        #0.5 rst_n = 1'b1;
        @(negedge clk);

        // Start at digit 2: must be ignored until digit 0
        show(2, PE, 8);
        show(3, PE, 8);
        expect_frame(16'h8765, 4'b0000, 1'b0);
        frame(P5, P6, P7, P8);

        // Digit 1 held too briefly, then rescanned
        show(0, P9, 8);
        chk("err_cleared", {31'd0, frame_err}, 32'd0);
        show(1, PA, 3);
        show(2, PB, 8);
        show(3, PC, 8);
        expect_frame(16'hCBA9, 4'b0000, 1'b0);
        show(1, PA, 8);

        // Illegal selects produce no captures
        drive_raw(4'b1100, 10);
        drive_raw(4'b1111, 10);
        drive_raw(4'b0000, 10);
        show(0, P0, 8);
        show(1, PE, 8);
        show(2, PD, 8);
        expect_frame(16'hFDE0, 4'b0000, 1'b0);
        show(3, PF, 8);

        // Blank digit 1
`ifdef SEG7_SCAN_RX_BLANK_EN
        expect_frame(16'hF309, 4'b0000, 1'b0);
`else
        expect_frame(16'hF309, 4'b0010, 1'b1);
`endif
        frame(P9, PBLANK, P3, PF);

        drive_raw(4'b1111, 10);
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
